axi_lite_regcheck_master: RTL

AXI_LITE_REGCHECK_MASTER -- requirements
Module: axi_lite_regcheck_master

---
 rtl/axi_lite_regcheck_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axi_lite_regcheck_master.sv
// AXI4-Lite register self-test master.
// Each pass walks C_NUM_REGS registers. For each one it writes seed+i, reads the value back,
// and counts the register as failed on a bad BRESP, a bad RRESP or a readback mismatch.
module axi_lite_regcheck_master #(
  parameter int unsigned             C_DATA_WIDTH = 32,
  parameter int unsigned             C_ADDR_WIDTH = 32,
  parameter int unsigned             C_NUM_REGS   = 4,
  parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = '0
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      start,
  input  logic [C_DATA_WIDTH-1:0]   seed,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [7:0]                err_count,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam logic [C_ADDR_WIDTH-1:0] AddrStep = C_ADDR_WIDTH'(C_DATA_WIDTH / 8);
  localparam logic [7:0]              LastIdx  = 8'(C_NUM_REGS - 1);

  typedef enum logic [2:0] {StIdle, StWrite, StWResp, StRAddr, StRData, StDone} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              idx_q, idx_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0] pat_q, pat_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    fail_q, fail_d;
  logic [7:0]              err_q, err_d;
  logic                    pass_q, pass_d;
  logic                    aw_ok, w_ok;

  // A channel counts as finished once its handshake happened now or earlier in this WRITE.
  assign aw_ok = aw_done_q | (M_AXI_AWVALID & M_AXI_AWREADY);
  assign w_ok  = w_done_q  | (M_AXI_WVALID  & M_AXI_WREADY);

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Datapath registers: index, address, pattern, handshake flags, error tally.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      idx_q     <= '0;
      addr_q    <= '0;
      pat_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      fail_q    <= 1'b0;
      err_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      pat_q     <= pat_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
    end
  end

  // Next-state logic; address and pattern advance incrementally, so no multiplier is needed.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    pat_d     = pat_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    fail_d    = fail_q;
    err_d     = err_q;
    pass_d    = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StWrite;
          idx_d     = '0;
          addr_d    = C_BASE_ADDR;
          pat_d     = seed;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          fail_d    = 1'b0;
          err_d     = '0;
          pass_d    = 1'b0;
        end
      end
      StWrite: begin
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) begin
          state_d   = StWResp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      StWResp: begin
        if (M_AXI_BVALID) begin
          state_d = StRAddr;
          if (M_AXI_BRESP != 2'b00) fail_d = 1'b1;
        end
      end
      StRAddr: begin
        if (M_AXI_ARREADY) state_d = StRData;
      end
      StRData: begin
        if (M_AXI_RVALID) begin
          // One increment per register at most, no matter how many checks failed.
          if ((fail_q || M_AXI_RRESP != 2'b00 || M_AXI_RDATA != pat_q) && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          fail_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            state_d = StWrite;
            idx_d   = idx_q + 8'd1;
            addr_d  = addr_q + AddrStep;
            pat_d   = pat_q + C_DATA_WIDTH'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        pass_d  = (err_q == 8'd0);
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from registered state, so VALIDs never depend on READYs.
  always_comb begin
    M_AXI_AWVALID = (state_q == StWrite) && !aw_done_q;
    M_AXI_WVALID  = (state_q == StWrite) && !w_done_q;
    M_AXI_WSTRB   = (state_q == StWrite) ? '1 : '0;
    M_AXI_BREADY  = (state_q == StWResp);
    M_AXI_ARVALID = (state_q == StRAddr);
    M_AXI_RREADY  = (state_q == StRData);
    M_AXI_AWADDR  = addr_q;
    M_AXI_ARADDR  = addr_q;
    M_AXI_WDATA   = pat_q;
    busy          = (state_q != StIdle);
    done          = (state_q == StDone);
    // Verdict is visible alongside done and then held in pass_q.
    pass          = pass_q | ((state_q == StDone) && (err_q == 8'd0));
    err_count     = err_q;
  end

endmodule
